// File: rtl/pot_scan.sv
// pot_scan: round-robin A2D pot scanner with per-slot IIR smoothing,
// inter-sweep gap, conversion timeout and sweep-complete strobe.
module pot_scan #(
    parameter int NUM_CH = 6,
    parameter int RES_W = 12,
    parameter logic [NUM_CH*3-1:0] CH_MAP = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
    parameter int AVG_LOG2 = 2,
    parameter int SCAN_GAP = 1024,
    parameter int TO_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        res,
    input  logic                    clr_err,
    output logic [2:0]              chnnl,
    output logic                    strt_cnv,
    output logic [NUM_CH*RES_W-1:0] pot_vals,
    output logic                    sweep_done,
    output logic                    timeout_err
);
    localparam int ACC_W = RES_W + AVG_LOG2;
    localparam int SLOT_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = TO_CYC > SCAN_GAP ? TO_CYC : SCAN_GAP;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, STORE, GAP} state_t;

    state_t            state, state_n;
    logic [SLOT_W-1:0] slot;
    logic [CNT_W-1:0]  cnt;
    logic [RES_W-1:0]  res_q;
    logic              vld, tmo, last;
    logic [NUM_CH-1:0] primed;
    logic [ACC_W-1:0]  acc [NUM_CH];

    assign last = slot == SLOT_W'(NUM_CH - 1);
    assign chnnl = CH_MAP[3*slot +: 3];
    assign strt_cnv = state == START;
    assign sweep_done = state == STORE && last;

    always_comb begin
        state_n = state;
        tmo = 1'b0;
        case (state)
            IDLE:  state_n = en ? START : IDLE;
            START: state_n = WAIT;
            WAIT: begin
                tmo = !cnv_cmplt && cnt == CNT_W'(TO_CYC - 1);
                state_n = (cnv_cmplt || tmo) ? STORE : WAIT;
            end
            STORE: state_n = (last && SCAN_GAP != 0) ? GAP : en ? START : IDLE;
            GAP:   state_n = cnt == CNT_W'(SCAN_GAP - 1) ? (en ? START : IDLE) : GAP;
            default: state_n = IDLE;
        endcase
    end

    // A timed-out conversion still passes through STORE (vld=0) so slot
    // advance and sweep_done behave exactly as for a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            slot <= '0;
            cnt <= '0;
            res_q <= '0;
            vld <= 1'b0;
            primed <= '0;
            timeout_err <= 1'b0;
            for (int j = 0; j < NUM_CH; j++) acc[j] <= '0;
        end else begin
            state <= state_n;
            cnt <= (state_n == state && (state == WAIT || state == GAP)) ? cnt + 1'b1 : '0;
            if (state == WAIT) begin
                res_q <= res;
                vld <= cnv_cmplt;
            end
            if (tmo) timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
            if (state == STORE) begin
                slot <= last ? '0 : slot + 1'b1;
                if (vld) begin
                    acc[slot] <= primed[slot] ? acc[slot] - (acc[slot] >> AVG_LOG2) + ACC_W'(res_q)
                                              : ACC_W'(res_q) << AVG_LOG2;
                    primed[slot] <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_out
        assign pot_vals[i*RES_W +: RES_W] = RES_W'(acc[i] >> AVG_LOG2);
    end
endmodule
